eth_pkt_rr_arb: RTL and testbench

- Packet-level round-robin arbiter that merges CHANNELS eth_pkt_if streams into one eth_pkt_if output.
- Switches source only at packet boundaries, so an output packet is never interleaved.
- Sits in front of shared resources such as a single TX MAC path or a capture FIFO.
- Output is fully registered.

---
 rtl/eth_pkt_lib.sv | 25 ++
 rtl/eth_pkt_rr_sel.sv | 41 ++++
 rtl/eth_pkt_rr_arb.sv | 163 ++++++++++++++++
 tb/tb_eth_pkt_rr_arb.sv | 535 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkt_lib.sv
// Shared types and width helpers for the eth_pkt stream blocks.
// Zero-width fields are widened to one bit.
package eth_pkt_lib;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PKT  = 1'b1
  } eth_pkt_rr_arb_state_t;

  localparam int unsigned STAT_W = 32;

  function automatic int unsigned one_for_zero(input int unsigned w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

  // Bits needed to count the valid bytes of a data beat
  function automatic int unsigned mod_width(input int unsigned data_w);
    return one_for_zero(32'($clog2(data_w / 32'd8)));
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return one_for_zero(32'($clog2(n)));
  endfunction

endpackage

// File: rtl/eth_pkt_rr_sel.sv
// Combinational round-robin picker: the first requester at or after last+1 wins.
// The request vector is doubled so the rotate needs no wrap logic.
module eth_pkt_rr_sel
  import eth_pkt_lib::*;
#(
  parameter int unsigned  CHANNELS = 4,
  localparam int unsigned CH_W     = idx_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CH_W-1:0]     last,
  output logic [CH_W-1:0]     gnt_idx,
  output logic                gnt_any
);

  logic [2*CHANNELS-1:0] dbl;
  logic [CHANNELS-1:0]   rot;
  logic                  found;
  int unsigned           off;
  int unsigned           sum;

  always_comb begin
    dbl   = {req, req} >> (32'(last) + 32'd1);
    rot   = dbl[CHANNELS-1:0];
    off   = 32'd0;
    found = 1'b0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (rot[i] && !found) begin
        off   = 32'(i);
        found = 1'b1;
      end
    end
    // Map the rotated offset back to an absolute channel number
    sum = 32'(last) + 32'd1 + off;
    if (sum >= CHANNELS) begin
      sum = sum - CHANNELS;
    end
    gnt_idx = CH_W'(sum);
    gnt_any = |req;
  end

endmodule

// File: rtl/eth_pkt_rr_arb.sv
// Packet-level round-robin merge of CHANNELS eth_pkt streams onto one registered output.
// Define ETH_PKT_RR_ARB_STAT_EN to add per-channel packet counters on pkt_cnt_o.
module eth_pkt_rr_arb
  import eth_pkt_lib::*;
#(
  parameter int unsigned  CHANNELS = 4,
  parameter int unsigned  DATA_W   = 64,
  parameter int unsigned  TUSER_W  = 1,
  localparam int unsigned MOD_W    = mod_width(DATA_W),
  localparam int unsigned TU_W     = one_for_zero(TUSER_W),
  localparam int unsigned CH_W     = idx_width(CHANNELS)
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [CHANNELS*DATA_W-1:0] in_data_i,
  input  logic [CHANNELS*MOD_W-1:0]  in_mod_i,
  input  logic [CHANNELS-1:0]        in_sop_i,
  input  logic [CHANNELS-1:0]        in_eop_i,
  input  logic [CHANNELS-1:0]        in_val_i,
  input  logic [CHANNELS*TU_W-1:0]   in_tuser_i,
  output logic [CHANNELS-1:0]        in_ready_o,
  output logic [DATA_W-1:0]          out_data_o,
  output logic [MOD_W-1:0]           out_mod_o,
  output logic                       out_sop_o,
  output logic                       out_eop_o,
  output logic                       out_val_o,
  output logic [TU_W-1:0]            out_tuser_o,
  input  logic                       out_ready_i,
  output logic [CH_W-1:0]            out_chan_o,
  output logic                       orphan_o
`ifdef ETH_PKT_RR_ARB_STAT_EN
  ,
  output logic [CHANNELS*STAT_W-1:0] pkt_cnt_o
`endif
);

  eth_pkt_rr_arb_state_t state;
  logic [CH_W-1:0]       grant;
  logic [CH_W-1:0]       last_grant;
  logic [CH_W-1:0]       sel_idx;
  logic                  sel_any;
  logic [CHANNELS-1:0]   req_c;
  logic [CHANNELS-1:0]   orphan_c;
  logic                  out_free;
  logic                  acc;
  logic                  g_val;
  logic                  g_sop;
  logic                  g_eop;
  logic [DATA_W-1:0]     g_data;
  logic [MOD_W-1:0]      g_mod;
  logic [TU_W-1:0]       g_tuser;

  eth_pkt_rr_sel #(
    .CHANNELS (CHANNELS)
  ) u_sel (
    .req     (req_c),
    .last    (last_grant),
    .gnt_idx (sel_idx),
    .gnt_any (sel_any)
  );

  // Request/orphan decode, granted-channel mux and per-channel ready
  always_comb begin
    req_c      = '0;
    orphan_c   = '0;
    in_ready_o = '0;
    g_val      = 1'b0;
    g_sop      = 1'b0;
    g_eop      = 1'b0;
    g_data     = '0;
    g_mod      = '0;
    g_tuser    = '0;
    out_free   = !out_val_o || out_ready_i;

    if (state == IDLE) begin
      req_c      = in_val_i & in_sop_i;
      orphan_c   = in_val_i & ~in_sop_i;
      in_ready_o = orphan_c;
    end

    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (grant == CH_W'(k)) begin
        g_val   = in_val_i[k];
        g_sop   = in_sop_i[k];
        g_eop   = in_eop_i[k];
        g_data  = in_data_i[k*DATA_W +: DATA_W];
        g_mod   = in_mod_i[k*MOD_W +: MOD_W];
        g_tuser = in_tuser_i[k*TU_W +: TU_W];
        if (state == PKT) begin
          in_ready_o[k] = out_free;
        end
      end
    end

    acc = (state == PKT) && out_free && g_val;
  end

  // Arbitration FSM and output register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= CH_W'(CHANNELS - 1);
      out_data_o  <= '0;
      out_mod_o   <= '0;
      out_sop_o   <= 1'b0;
      out_eop_o   <= 1'b0;
      out_val_o   <= 1'b0;
      out_tuser_o <= '0;
      out_chan_o  <= '0;
      orphan_o    <= 1'b0;
    end else begin
      if (|orphan_c) begin
        orphan_o <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (sel_any) begin
            grant      <= sel_idx;
            last_grant <= sel_idx;
            state      <= PKT;
          end
        end
        PKT: begin
          // Grant is held through gaps and new requests until eop is taken
          if (acc && g_eop) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (acc) begin
        out_data_o  <= g_data;
        out_mod_o   <= g_mod;
        out_sop_o   <= g_sop;
        out_eop_o   <= g_eop;
        out_tuser_o <= g_tuser;
        out_chan_o  <= grant;
        out_val_o   <= 1'b1;
      end else if (out_ready_i) begin
        out_val_o <= 1'b0;
      end
    end
  end

`ifdef ETH_PKT_RR_ARB_STAT_EN
  // Count packets as their eop leaves the output register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pkt_cnt_o <= '0;
    end else if (out_val_o && out_ready_i && out_eop_o) begin
      for (int k = 0; k < int'(CHANNELS); k++) begin
        if (out_chan_o == CH_W'(k)) begin
          pkt_cnt_o[k*STAT_W +: STAT_W] <= pkt_cnt_o[k*STAT_W +: STAT_W] + STAT_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_eth_pkt_rr_arb.sv
// Randomized bench for eth_pkt_rr_arb: per-channel FIFO scoreboard plus
// round-robin order, framing and handshake rules computed in the bench.
`timescale 1ns/1ps
module tb_eth_pkt_rr_arb;

  localparam int CH = 4;
  localparam int DW = 64;
  localparam int MW = 3;
  localparam int TW = 1;
  localparam int CW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [MW-1:0] mod;
    logic          sop;
    logic          eop;
    logic [TW-1:0] tuser;
  } beat_t;

  typedef struct {
    beat_t b;
    int    chan;
    int    cyc;
  } obs_t;

  logic             clk_i;
  logic             rst_n_i;
  logic [CH*DW-1:0] in_data_i;
  logic [CH*MW-1:0] in_mod_i;
  logic [CH-1:0]    in_sop_i;
  logic [CH-1:0]    in_eop_i;
  logic [CH-1:0]    in_val_i;
  logic [CH*TW-1:0] in_tuser_i;
  logic [CH-1:0]    in_ready_o;
  logic [DW-1:0]    out_data_o;
  logic [MW-1:0]    out_mod_o;
  logic             out_sop_o;
  logic             out_eop_o;
  logic             out_val_o;
  logic [TW-1:0]    out_tuser_o;
  logic             out_ready_i;
  logic [CW-1:0]    out_chan_o;
  logic             orphan_o;
`ifdef ETH_PKT_RR_ARB_STAT_EN
  logic [CH*32-1:0] pkt_cnt_o;
`endif

  eth_pkt_rr_arb #(
    .CHANNELS (CH),
    .DATA_W   (DW),
    .TUSER_W  (TW)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_data_i   (in_data_i),
    .in_mod_i    (in_mod_i),
    .in_sop_i    (in_sop_i),
    .in_eop_i    (in_eop_i),
    .in_val_i    (in_val_i),
    .in_tuser_i  (in_tuser_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (out_data_o),
    .out_mod_o   (out_mod_o),
    .out_sop_o   (out_sop_o),
    .out_eop_o   (out_eop_o),
    .out_val_o   (out_val_o),
    .out_tuser_o (out_tuser_o),
    .out_ready_i (out_ready_i),
    .out_chan_o  (out_chan_o),
    .orphan_o    (orphan_o)
`ifdef ETH_PKT_RR_ARB_STAT_EN
    ,
    .pkt_cnt_o   (pkt_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  beat_t   src_q[CH][$];
  beat_t   exp_q[CH][$];
  obs_t    obs_q[$];
  int      gap_pct[CH];
  bit      en[CH];
  int      rdy_mode;
  bit      manual;
  int      cyc;
  logic [CH-1:0] s_ready;
  logic [CH-1:0] s_acc;
  logic    s_oval;
  logic    s_ordy;
  beat_t   s_pop[CH];
  int      vectors;
  int      miscompares;

  task automatic clear_env();
    for (int k = 0; k < CH; k++) begin
      src_q[k].delete();
      exp_q[k].delete();
      en[k]      = 1'b1;
      gap_pct[k] = 0;
    end
    obs_q.delete();
    rdy_mode = 0;
    manual   = 1'b0;
  endtask

  task automatic zero_inputs();
    in_data_i  = '0;
    in_mod_i   = '0;
    in_sop_i   = '0;
    in_eop_i   = '0;
    in_val_i   = '0;
    in_tuser_i = '0;
  endtask

  task automatic gen_pkt(input int ch, input int len, input int mod_last);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data  = {$urandom, $urandom};
      b.mod   = (mod_last >= 0) ? MW'(mod_last) : MW'($urandom);
      b.sop   = (i == 0);
      b.eop   = (i == len - 1);
      b.tuser = TW'($urandom);
      src_q[ch].push_back(b);
      exp_q[ch].push_back(b);
    end
  endtask

  task automatic drive_inputs();
    beat_t b;
    for (int k = 0; k < CH; k++) begin
      b = '0;
      in_val_i[k] = 1'b0;
      if (en[k] && src_q[k].size() > 0 && int'($urandom_range(99)) >= gap_pct[k]) begin
        b = src_q[k][0];
        in_val_i[k] = 1'b1;
      end
      in_data_i[k*DW +: DW]  = b.data;
      in_mod_i[k*MW +: MW]   = b.mod;
      in_sop_i[k]            = b.sop;
      in_eop_i[k]            = b.eop;
      in_tuser_i[k*TW +: TW] = b.tuser;
    end
    case (rdy_mode)
      0:       out_ready_i = 1'b1;
      1:       out_ready_i = ((cyc % 3) == 0);
      default: out_ready_i = (int'($urandom_range(99)) < 70);
    endcase
  endtask

  // One clock: drive, sample at negedge, consume accepted beats after posedge
  task automatic tick();
    obs_t o;
    if (!manual) drive_inputs();
    @(negedge clk_i);
    s_ready = in_ready_o;
    s_acc   = in_val_i & in_ready_o;
    s_oval  = out_val_o;
    s_ordy  = out_ready_i;
    if (out_val_o && out_ready_i) begin
      o.b.data  = out_data_o;
      o.b.mod   = out_mod_o;
      o.b.sop   = out_sop_o;
      o.b.eop   = out_eop_o;
      o.b.tuser = out_tuser_o;
      o.chan    = int'(out_chan_o);
      o.cyc     = cyc;
      obs_q.push_back(o);
    end
    @(posedge clk_i);
    #1;
    cyc++;
    if (!manual) begin
      for (int k = 0; k < CH; k++) begin
        if (s_acc[k] && src_q[k].size() > 0) s_pop[k] = src_q[k].pop_front();
      end
    end
  endtask

  task automatic drain(input int max_cyc, output bit ok);
    int  n;
    bit  empty;
    n  = 0;
    ok = 1'b0;
    while (n < max_cyc && !ok) begin
      tick();
      n++;
      empty = 1'b1;
      for (int k = 0; k < CH; k++) if (src_q[k].size() > 0) empty = 1'b0;
      if (empty && !out_val_o) ok = 1'b1;
    end
  endtask

  function automatic beat_t sb_pop(input int ch, output bit ok);
    beat_t e;
    e  = '0;
    ok = 1'b0;
    if (ch >= 0 && ch < CH && exp_q[ch].size() > 0) begin
      e  = exp_q[ch].pop_front();
      ok = 1'b1;
    end
    return e;
  endfunction

  task automatic test_reset();
    manual      = 1'b1;
    rst_n_i     = 1'b0;
    out_ready_i = 1'b0;
    zero_inputs();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    vectors++;
    if (out_val_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_val: got %b want 0", out_val_o);
    end
    vectors++;
    if ({out_sop_o, out_eop_o, out_chan_o, out_mod_o, out_tuser_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctl: got sop%b eop%b ch%0d mod%0d tu%0d want all 0",
               out_sop_o, out_eop_o, out_chan_o, out_mod_o, out_tuser_o);
    end
    vectors++;
    if (out_data_o !== '0) begin
      miscompares++; $display("FAIL reset_data: got %h want 0", out_data_o);
    end
    vectors++;
    if (orphan_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_orphan: got %b want 0", orphan_o);
    end
    vectors++;
    if (in_ready_o !== '0) begin
      miscompares++; $display("FAIL reset_ready: got %b want 0000", in_ready_o);
    end
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    manual = 1'b0;
  endtask

  task automatic test_fairness();
    bit    ok;
    beat_t e;
    clear_env();
    for (int p = 0; p < 2; p++) for (int k = 0; k < CH; k++) gen_pkt(k, 3, -1);
    drain(200, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL fair_drain: got timeout want drained"); end
    vectors++;
    if (obs_q.size() != 24) begin
      miscompares++; $display("FAIL fair_count: got %0d want 24", obs_q.size());
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      e = sb_pop(obs_q[i].chan, ok);
      vectors++;
      if (!ok || obs_q[i].b !== e || obs_q[i].chan != (i / 3) % CH) begin
        miscompares++;
        $display("FAIL fair_beat %0d: got ch%0d %h want ch%0d %h", i, obs_q[i].chan,
                 obs_q[i].b, (i / 3) % CH, e);
      end
      if (i > 0) begin
        vectors++;
        if (obs_q[i].cyc - obs_q[i-1].cyc != ((i % 3 == 0) ? 2 : 1)) begin
          miscompares++;
          $display("FAIL fair_gap %0d: got %0d want %0d", i, obs_q[i].cyc - obs_q[i-1].cyc,
                   (i % 3 == 0) ? 2 : 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit    ok;
    bit    in_pkt;
    int    n;
    beat_t e;
    clear_env();
    rdy_mode = 1;
    gen_pkt(2, 5, -1);
    in_pkt = 1'b0;
    n = 0;
    while (src_q[2].size() > 0 && n < 100) begin
      tick();
      n++;
      if (in_pkt) begin
        vectors++;
        if (s_ready[2] !== (!s_oval || s_ordy)) begin
          miscompares++;
          $display("FAIL bp_ready cyc %0d: got %b want %b", cyc, s_ready[2], !s_oval || s_ordy);
        end
      end
      if (s_acc[2] && s_pop[2].sop) in_pkt = 1'b1;
      if (s_acc[2] && s_pop[2].eop) in_pkt = 1'b0;
    end
    drain(100, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL bp_drain: got timeout want drained"); end
    vectors++;
    if (obs_q.size() != 5) begin
      miscompares++; $display("FAIL bp_count: got %0d want 5", obs_q.size());
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      e = sb_pop(2, ok);
      vectors++;
      if (!ok || obs_q[i].b !== e || obs_q[i].chan != 2) begin
        miscompares++;
        $display("FAIL bp_beat %0d: got ch%0d %h want ch2 %h", i, obs_q[i].chan, obs_q[i].b, e);
      end
    end
  endtask

  task automatic test_single_beat();
    bit    ok;
    beat_t e;
    clear_env();
    for (int i = 0; i < 3; i++) begin
      gen_pkt(0, 1, 3);
      gen_pkt(1, 1, 3);
    end
    drain(100, ok);
    vectors++;
    if (!ok || obs_q.size() != 6) begin
      miscompares++; $display("FAIL single_count: got %0d ok%b want 6", obs_q.size(), ok);
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      e = sb_pop(obs_q[i].chan, ok);
      vectors++;
      if (!ok || obs_q[i].b !== e || obs_q[i].chan != i % 2 ||
          !obs_q[i].b.sop || !obs_q[i].b.eop || obs_q[i].b.mod != 3'd3) begin
        miscompares++;
        $display("FAIL single_beat %0d: got ch%0d sop%b eop%b mod%0d want ch%0d sop1 eop1 mod3",
                 i, obs_q[i].chan, obs_q[i].b.sop, obs_q[i].b.eop, obs_q[i].b.mod, i % 2);
      end
    end
  endtask

  task automatic test_no_interleave();
    bit    ok;
    int    n;
    int    want_ch;
    beat_t e;
    clear_env();
    gap_pct[1] = 40;
    en[0]      = 1'b0;
    gen_pkt(1, 4, -1);
    gen_pkt(0, 2, -1);
    n = 0;
    while (!s_acc[1] && n < 50) begin
      tick();
      n++;
    end
    en[0] = 1'b1;
    drain(300, ok);
    vectors++;
    if (!ok || obs_q.size() != 6) begin
      miscompares++; $display("FAIL nointl_count: got %0d ok%b want 6", obs_q.size(), ok);
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      want_ch = (i < 4) ? 1 : 0;
      e = sb_pop(obs_q[i].chan, ok);
      vectors++;
      if (!ok || obs_q[i].b !== e || obs_q[i].chan != want_ch) begin
        miscompares++;
        $display("FAIL nointl_beat %0d: got ch%0d %h want ch%0d %h", i, obs_q[i].chan,
                 obs_q[i].b, want_ch, e);
      end
    end
  endtask

  task automatic test_orphan();
    clear_env();
    manual      = 1'b1;
    out_ready_i = 1'b1;
    zero_inputs();
    in_val_i[3] = 1'b1;
    in_data_i[3*DW +: DW] = {$urandom, $urandom};
    tick();
    vectors++;
    if (s_ready !== 4'b1000) begin
      miscompares++; $display("FAIL orphan_ready: got %b want 1000", s_ready);
    end
    vectors++;
    if (orphan_o !== 1'b1) begin
      miscompares++; $display("FAIL orphan_set: got %b want 1", orphan_o);
    end
    zero_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (s_oval !== 1'b0 || orphan_o !== 1'b1) begin
        miscompares++;
        $display("FAIL orphan_hold %0d: got val%b flag%b want val0 flag1", i, s_oval, orphan_o);
      end
    end
    manual = 1'b0;
  endtask

  task automatic test_random();
    bit    ok;
    int    open_ch;
    beat_t e;
    clear_env();
    rdy_mode = 2;
    for (int k = 0; k < CH; k++) begin
      gap_pct[k] = int'($urandom_range(50));
      for (int p = 0; p < 5; p++) gen_pkt(k, int'($urandom_range(6, 1)), -1);
    end
    drain(3000, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rand_drain: got timeout want drained"); end
    open_ch = -1;
    for (int i = 0; i < obs_q.size(); i++) begin
      e = sb_pop(obs_q[i].chan, ok);
      vectors++;
      if (!ok || obs_q[i].b !== e) begin
        miscompares++;
        $display("FAIL rand_beat %0d: got ch%0d %h want %h", i, obs_q[i].chan, obs_q[i].b, e);
      end
      if (open_ch >= 0) begin
        vectors++;
        if (obs_q[i].chan != open_ch) begin
          miscompares++;
          $display("FAIL rand_interleave %0d: got ch%0d want ch%0d", i, obs_q[i].chan, open_ch);
        end
      end
      open_ch = obs_q[i].b.eop ? -1 : obs_q[i].chan;
    end
    for (int k = 0; k < CH; k++) begin
      vectors++;
      if (exp_q[k].size() != 0) begin
        miscompares++; $display("FAIL rand_left ch%0d: got %0d beats missing want 0", k, exp_q[k].size());
      end
    end
  endtask

  task automatic test_reset_mid();
    bit    ok;
    int    got;
    int    n;
    int    want_ch;
    beat_t e;
    clear_env();
    gen_pkt(2, 4, -1);
    got = 0;
    n   = 0;
    while (got < 2 && n < 50) begin
      tick();
      n++;
      if (s_acc[2]) got++;
    end
    manual = 1'b1;
    #2;
    zero_inputs();
    rst_n_i = 1'b0;
    #1;
    vectors++;
    if ({out_val_o, out_sop_o, out_eop_o, out_chan_o, out_mod_o, out_tuser_o, orphan_o} !== '0 ||
        out_data_o !== '0) begin
      miscompares++;
      $display("FAIL midrst_out: got val%b sop%b eop%b ch%0d data%h orphan%b want all 0",
               out_val_o, out_sop_o, out_eop_o, out_chan_o, out_data_o, orphan_o);
    end
    vectors++;
    if (in_ready_o !== '0) begin
      miscompares++; $display("FAIL midrst_ready: got %b want 0000", in_ready_o);
    end
`ifdef ETH_PKT_RR_ARB_STAT_EN
    vectors++;
    if (pkt_cnt_o !== '0) begin
      miscompares++; $display("FAIL midrst_cnt: got %h want 0", pkt_cnt_o);
    end
`endif
    clear_env();
    manual = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    manual = 1'b0;
    gen_pkt(3, 2, -1);
    gen_pkt(0, 2, -1);
    drain(100, ok);
    vectors++;
    if (!ok || obs_q.size() != 4) begin
      miscompares++; $display("FAIL midrst_count: got %0d ok%b want 4", obs_q.size(), ok);
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      want_ch = (i < 2) ? 0 : 3;
      e = sb_pop(obs_q[i].chan, ok);
      vectors++;
      if (!ok || obs_q[i].b !== e || obs_q[i].chan != want_ch) begin
        miscompares++;
        $display("FAIL midrst_beat %0d: got ch%0d %h want ch%0d %h", i, obs_q[i].chan,
                 obs_q[i].b, want_ch, e);
      end
    end
`ifdef ETH_PKT_RR_ARB_STAT_EN
    vectors++;
    if (pkt_cnt_o[0 +: 32] !== 32'd1 || pkt_cnt_o[3*32 +: 32] !== 32'd1 ||
        pkt_cnt_o[32 +: 64] !== 64'd0) begin
      miscompares++; $display("FAIL midrst_stat: got %h want ch0=1 ch3=1 others 0", pkt_cnt_o);
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    s_ready     = '0;
    s_acc       = '0;
    s_oval      = 1'b0;
    s_ordy      = 1'b0;
    clear_env();
    zero_inputs();
    test_reset();
    test_fairness();
    test_backpressure();
    test_single_beat();
    test_no_interleave();
    test_orphan();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
